// File: rtl/cmsdk_iop_gpio_arbiter.sv
// Two-requester arbiter in front of a single IOP slave: one command latched per grant,
// a one-cycle IOSEL/IOTRANS beat, then an ACK with read data to the granted requester.
module cmsdk_iop_gpio_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int AW            = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,

    input  logic          M0_REQ,
    input  logic [AW-1:0] M0_ADDR,
    input  logic          M0_WRITE,
    input  logic [1:0]    M0_SIZE,
    input  logic [31:0]   M0_WDATA,
    output logic          M0_ACK,
    output logic [31:0]   M0_RDATA,

    input  logic          M1_REQ,
    input  logic [AW-1:0] M1_ADDR,
    input  logic          M1_WRITE,
    input  logic [1:0]    M1_SIZE,
    input  logic [31:0]   M1_WDATA,
    output logic          M1_ACK,
    output logic [31:0]   M1_RDATA,

    output logic          IOSEL,
    output logic          IOTRANS,
    output logic [AW-1:0] IOADDR,
    output logic          IOWRITE,
    output logic [1:0]    IOSIZE,
    output logic [31:0]   IOWDATA,
    input  logic [31:0]   IORDATA,

    output logic          BUSY,
    output logic          LAST_GNT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          do_grant;
    logic          gnt_idx;
    logic          other_req;

    logic          iosel_q;
    logic          busy_q;
    logic          m0_ack_q;
    logic          m1_ack_q;
    logic          last_gnt_q;
    logic [AW-1:0] ioaddr_q;
    logic          iowrite_q;
    logic [1:0]    iosize_q;
    logic [31:0]   iowdata_q;

    // In WAIT the requester being acknowledged is masked; only the other one may be granted.
    assign other_req = last_gnt_q ? M0_REQ : M1_REQ;

    always_comb begin
        do_grant  = 1'b0;
        gnt_idx   = 1'b0;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_ISSUE;
                    if (M0_REQ && M1_REQ)
                        gnt_idx = (PRIORITY_MODE != 0) ? 1'b0 : ~last_gnt_q;
                    else
                        gnt_idx = M1_REQ;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (other_req) begin
                    do_grant  = 1'b1;
                    gnt_idx   = ~last_gnt_q;
                    state_nxt = ST_ISSUE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            iosel_q    <= 1'b0;
            busy_q     <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            ioaddr_q   <= '0;
            iowrite_q  <= 1'b0;
            iosize_q   <= '0;
            iowdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            iosel_q  <= (state_nxt == ST_ISSUE);
            busy_q   <= (state_nxt != ST_IDLE);
            m0_ack_q <= (state == ST_ISSUE) && !last_gnt_q;
            m1_ack_q <= (state == ST_ISSUE) &&  last_gnt_q;
            if (do_grant) begin
                last_gnt_q <= gnt_idx;
                ioaddr_q   <= gnt_idx ? M1_ADDR  : M0_ADDR;
                iowrite_q  <= gnt_idx ? M1_WRITE : M0_WRITE;
                iosize_q   <= gnt_idx ? M1_SIZE  : M0_SIZE;
                iowdata_q  <= gnt_idx ? M1_WDATA : M0_WDATA;
            end
        end
    end

    assign IOSEL    = iosel_q;
    assign IOTRANS  = iosel_q;
    assign IOADDR   = ioaddr_q;
    assign IOWRITE  = iowrite_q;
    assign IOSIZE   = iosize_q;
    assign IOWDATA  = iowdata_q;
    assign BUSY     = busy_q;
    assign LAST_GNT = last_gnt_q;
    assign M0_ACK   = m0_ack_q;
    assign M1_ACK   = m1_ack_q;
    // Slave data arrives in the cycle after the beat, which is exactly the ACK cycle.
    assign M0_RDATA = m0_ack_q ? IORDATA : '0;
    assign M1_RDATA = m1_ack_q ? IORDATA : '0;

endmodule

// File: tb/tb_cmsdk_iop_gpio_arbiter.sv
// Bench for cmsdk_iop_gpio_arbiter: round-robin and fixed-priority instances share stimulus,
// each checked every cycle against a grant-timeline model.
module tb_cmsdk_iop_gpio_arbiter;
    localparam int AW = 12;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_write, m1_write;
    logic [1:0]    m0_size, m1_size;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [31:0]   iordata;

    logic          m0_ack[2], m1_ack[2], iosel[2], iotrans[2], iowrite[2], busy[2], last_gnt[2];
    logic [31:0]   m0_rdata[2], m1_rdata[2], iowdata[2];
    logic [AW-1:0] ioaddr[2];
    logic [1:0]    iosize[2];

    cmsdk_iop_gpio_arbiter #(.PRIORITY_MODE(0), .AW(AW)) u_rr (
        .HCLK(clk), .HRESET(rst),
        .M0_REQ(m0_req), .M0_ADDR(m0_addr), .M0_WRITE(m0_write), .M0_SIZE(m0_size),
        .M0_WDATA(m0_wdata), .M0_ACK(m0_ack[0]), .M0_RDATA(m0_rdata[0]),
        .M1_REQ(m1_req), .M1_ADDR(m1_addr), .M1_WRITE(m1_write), .M1_SIZE(m1_size),
        .M1_WDATA(m1_wdata), .M1_ACK(m1_ack[0]), .M1_RDATA(m1_rdata[0]),
        .IOSEL(iosel[0]), .IOTRANS(iotrans[0]), .IOADDR(ioaddr[0]), .IOWRITE(iowrite[0]),
        .IOSIZE(iosize[0]), .IOWDATA(iowdata[0]), .IORDATA(iordata),
        .BUSY(busy[0]), .LAST_GNT(last_gnt[0])
    );

    cmsdk_iop_gpio_arbiter #(.PRIORITY_MODE(1), .AW(AW)) u_fp (
        .HCLK(clk), .HRESET(rst),
        .M0_REQ(m0_req), .M0_ADDR(m0_addr), .M0_WRITE(m0_write), .M0_SIZE(m0_size),
        .M0_WDATA(m0_wdata), .M0_ACK(m0_ack[1]), .M0_RDATA(m0_rdata[1]),
        .M1_REQ(m1_req), .M1_ADDR(m1_addr), .M1_WRITE(m1_write), .M1_SIZE(m1_size),
        .M1_WDATA(m1_wdata), .M1_ACK(m1_ack[1]), .M1_RDATA(m1_rdata[1]),
        .IOSEL(iosel[1]), .IOTRANS(iotrans[1]), .IOADDR(ioaddr[1]), .IOWRITE(iowrite[1]),
        .IOSIZE(iosize[1]), .IOWDATA(iowdata[1]), .IORDATA(iordata),
        .BUSY(busy[1]), .LAST_GNT(last_gnt[1])
    );

    int errors = 0;
    int checks = 0;

    // Model: each instance is described only by the edge number of its latest grant.
    // Grant at edge g -> beat after g, ACK after g+1, next grant possible from edge g+2.
    int            t = 0;
    int            g_time[2];
    int            g_who[2];
    int            mlast[2];
    logic [AW-1:0] maddr[2];
    logic          mwrite[2];
    logic [1:0]    msize[2];
    logic [31:0]   mwdata[2];

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] t=%0d observed=%h expected=%h", tag, i, t, obs, exp);
        end
    endtask

    function automatic logic eack(input int i, input int n);
        return (t == g_time[i] + 1) && (g_who[i] == n);
    endfunction

    task automatic model_edge();
        t++;
        for (int i = 0; i < 2; i++) begin
            logic r0, r1;
            int   who;
            if (rst) begin
                g_time[i] = -100; g_who[i] = 0; mlast[i] = 1;
                maddr[i] = '0; mwrite[i] = 1'b0; msize[i] = '0; mwdata[i] = '0;
            end else if (t - g_time[i] >= 2) begin
                r0 = m0_req && !(t == g_time[i] + 2 && g_who[i] == 0);
                r1 = m1_req && !(t == g_time[i] + 2 && g_who[i] == 1);
                if (r0 || r1) begin
                    if (r0 && r1) who = (i == 1) ? 0 : (mlast[i] == 1 ? 0 : 1);
                    else          who = r1 ? 1 : 0;
                    g_time[i] = t; g_who[i] = who; mlast[i] = who;
                    maddr[i]  = (who == 1) ? m1_addr  : m0_addr;
                    mwrite[i] = (who == 1) ? m1_write : m0_write;
                    msize[i]  = (who == 1) ? m1_size  : m0_size;
                    mwdata[i] = (who == 1) ? m1_wdata : m0_wdata;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("iosel",    i, 32'(iosel[i]),    32'(g_time[i] == t));
            chk("iotrans",  i, 32'(iotrans[i]),  32'(g_time[i] == t));
            chk("busy",     i, 32'(busy[i]),     32'(g_time[i] == t || g_time[i] + 1 == t));
            chk("m0_ack",   i, 32'(m0_ack[i]),   32'(eack(i, 0)));
            chk("m1_ack",   i, 32'(m1_ack[i]),   32'(eack(i, 1)));
            chk("m0_rdata", i, m0_rdata[i],      eack(i, 0) ? iordata : 32'h0);
            chk("m1_rdata", i, m1_rdata[i],      eack(i, 1) ? iordata : 32'h0);
            chk("last_gnt", i, 32'(last_gnt[i]), 32'(mlast[i]));
            chk("ioaddr",   i, 32'(ioaddr[i]),   32'(maddr[i]));
            chk("iowrite",  i, 32'(iowrite[i]),  32'(mwrite[i]));
            chk("iosize",   i, 32'(iosize[i]),   32'(msize[i]));
            chk("iowdata",  i, iowdata[i],       mwdata[i]);
        end
    endtask

    task automatic new_cmd0();
        m0_addr = AW'($urandom); m0_write = 1'($urandom);
        m0_size = 2'($urandom_range(0, 2)); m0_wdata = $urandom;
    endtask

    task automatic new_cmd1();
        m1_addr = AW'($urandom); m1_write = 1'($urandom);
        m1_size = 2'($urandom_range(0, 2)); m1_wdata = $urandom;
    endtask

    // Requesters that keep REQ high and present a fresh command after each ACK (RR instance).
    task automatic drive_hold();
        iordata = $urandom;
        if (m0_req && eack(0, 0)) new_cmd0();
        if (m1_req && eack(0, 1)) new_cmd1();
    endtask

    task automatic drive_random();
        rst     = ($urandom_range(0, 79) == 0);
        iordata = $urandom;
        if (m0_req) begin
            if (eack(0, 0)) begin
                if ($urandom_range(0, 1) == 0) m0_req = 1'b0; else new_cmd0();
            end else if ($urandom_range(0, 49) == 0) m0_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            m0_req = 1'b1; new_cmd0();
        end
        if (m1_req) begin
            if (eack(0, 1)) begin
                if ($urandom_range(0, 1) == 0) m1_req = 1'b0; else new_cmd1();
            end else if ($urandom_range(0, 49) == 0) m1_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            m1_req = 1'b1; new_cmd1();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            g_time[i] = -100; g_who[i] = 0; mlast[i] = 1;
            maddr[i] = '0; mwrite[i] = 1'b0; msize[i] = '0; mwdata[i] = '0;
        end
        rst = 1'b1; iordata = '0;
        m0_req = 1'b0; m0_addr = '0; m0_write = 1'b0; m0_size = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_write = 1'b0; m1_size = '0; m1_wdata = '0;
        step(); step();
        chk("rst_last_gnt", 0, 32'(last_gnt[0]), 32'd1);
        chk("rst_busy",     0, 32'(busy[0]),     32'd0);
        rst = 1'b0;
        step();

        // Single read from M0
        m0_req = 1'b1; m0_addr = '0; m0_write = 1'b0; m0_size = 2'b10; iordata = 32'h0000_A5A5;
        step();
        chk("t1_iotrans", 0, 32'(iotrans[0]), 32'd1);
        chk("t1_ioaddr",  0, 32'(ioaddr[0]),  32'h000);
        step();
        chk("t1_ack",   0, 32'(m0_ack[0]), 32'd1);
        chk("t1_rdata", 0, m0_rdata[0],    32'h0000_A5A5);
        chk("t1_m1ack", 0, 32'(m1_ack[0]), 32'd0);
        m0_req = 1'b0;
        step(); step();

        // Both requesting continuously: alternation in both modes
        m0_req = 1'b1; new_cmd0(); m1_req = 1'b1; new_cmd1();
        for (int k = 0; k < 18; k++) begin
            step();
            drive_hold();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(); step(); step();

        // M1 write
        m1_req = 1'b1; m1_addr = AW'(12'h004); m1_write = 1'b1; m1_size = 2'b10;
        m1_wdata = 32'hFFFF_0000;
        step();
        chk("t4_iowdata", 0, iowdata[0],        32'hFFFF_0000);
        chk("t4_iowrite", 0, 32'(iowrite[0]),   32'd1);
        chk("t4_iosize",  0, 32'(iosize[0]),    32'd2);
        step();
        chk("t4_ack", 0, 32'(m1_ack[0]), 32'd1);
        m1_req = 1'b0;
        step();
        chk("t4_ack_once", 0, 32'(m1_ack[0]), 32'd0);
        step();

        // Reset during ISSUE, request held across it
        m0_req = 1'b1; new_cmd0();
        step();
        rst = 1'b1;
        step();
        chk("t5_iosel", 0, 32'(iosel[0]),  32'd0);
        chk("t5_ack",   0, 32'(m0_ack[0]), 32'd0);
        rst = 1'b0;
        step();
        chk("t5_regrant", 0, 32'(iotrans[0]), 32'd1);
        step();
        chk("t5_ack2", 0, 32'(m0_ack[0]), 32'd1);
        m0_req = 1'b0;
        step(); step();

        // REQ dropped right after grant: transfer still completes once
        m0_req = 1'b1; new_cmd0();
        step();
        m0_req = 1'b0;
        step();
        chk("t6_ack", 0, 32'(m0_ack[0]), 32'd1);
        step();
        chk("t6_noresend", 0, 32'(iotrans[0]), 32'd0);
        step();

        // Random traffic including occasional resets and early REQ drops
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
